// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, loader port and memory-side signals of imem_arbiter.
// The arbiter connects through the slave modport; requesters and memory sit on the master side.
`timescale 1ns/1ps
interface imem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_err;

  logic        mem_ren;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_ren, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_ren, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port (fetch / loader) arbiter in front of a single-ported instruction memory, one access in flight.
// Define IMEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise fetch has fixed priority.
`timescale 1ns/1ps
module imem_arbiter (
  input  logic          clk,
  input  logic          resetn,
  imem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        sel_l;
  logic        we_lat;
  logic        mis_lat;

  logic        pick_l;
  logic        pick_we;
  logic        pick_mis;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;

`ifdef IMEM_ARB_RR_EN
  logic        last_l;
`endif

  always_comb begin
`ifdef IMEM_ARB_RR_EN
    // On a tie, the port that did not win the previous grant goes next.
    if (bus.f_req && bus.l_req) pick_l = !last_l;
    else                        pick_l = bus.l_req;
`else
    pick_l = bus.l_req && !bus.f_req;
`endif
    pick_addr  = pick_l ? bus.l_addr : bus.f_addr;
    pick_we    = pick_l && bus.l_we;
    pick_wdata = pick_we ? bus.l_wdata : 32'h0;
    pick_mis   = (pick_addr[1:0] != 2'b00);
  end

  // mem_rdata is captured on the edge that ends the ACCESS cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      sel_l         <= 1'b0;
      we_lat        <= 1'b0;
      mis_lat       <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      last_l        <= 1'b1;
`endif
      bus.f_gnt     <= 1'b0;
      bus.f_rvalid  <= 1'b0;
      bus.f_rdata   <= 32'h0;
      bus.f_err     <= 1'b0;
      bus.l_gnt     <= 1'b0;
      bus.l_rvalid  <= 1'b0;
      bus.l_rdata   <= 32'h0;
      bus.l_err     <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else begin
      bus.f_gnt     <= 1'b0;
      bus.f_rvalid  <= 1'b0;
      bus.f_rdata   <= 32'h0;
      bus.f_err     <= 1'b0;
      bus.l_gnt     <= 1'b0;
      bus.l_rvalid  <= 1'b0;
      bus.l_rdata   <= 32'h0;
      bus.l_err     <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;

      case (state)
        ACCESS: begin
          state <= RESP;
          if (sel_l) begin
            bus.l_rvalid <= 1'b1;
            bus.l_err    <= mis_lat;
            bus.l_rdata  <= (mis_lat || we_lat) ? 32'h0 : bus.mem_rdata;
          end else begin
            bus.f_rvalid <= 1'b1;
            bus.f_err    <= mis_lat;
            bus.f_rdata  <= mis_lat ? 32'h0 : bus.mem_rdata;
          end
        end
        default: begin
          // IDLE and RESP both arbitrate, giving back-to-back accesses every 2 cycles.
          if (bus.f_req || bus.l_req) begin
            state         <= ACCESS;
            sel_l         <= pick_l;
            we_lat        <= pick_we;
            mis_lat       <= pick_mis;
`ifdef IMEM_ARB_RR_EN
            last_l        <= pick_l;
`endif
            bus.f_gnt     <= !pick_l;
            bus.l_gnt     <= pick_l;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
            bus.mem_ren   <= !pick_mis && !pick_we;
            bus.mem_we    <= !pick_mis && pick_we;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_imem_arbiter;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  imem_arbiter_if bus();
  imem_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory contents are a fixed function of address; garbage when not read-strobed.
  always_comb bus.mem_rdata = bus.mem_ren ? mem_fn(bus.mem_addr) : 32'hBAD0_BAD0;

  // {f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, mem_ren, mem_we}
  function automatic logic [7:0] ctl();
    return {bus.f_gnt, bus.f_rvalid, bus.f_err, bus.l_gnt, bus.l_rvalid, bus.l_err,
            bus.mem_ren, bus.mem_we};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("reset_ctl",   64'(ctl()), 64'h0);
    chk("reset_rdata", {bus.f_rdata, bus.l_rdata}, 64'h0);
    chk("reset_mem",   {bus.mem_addr, bus.mem_wdata}, 64'h0);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255)) & 32'hFFFF_FFFC;
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [7:0]  e_g;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [7:0]  e_r;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[6];

  // Transaction-level model state for the random phase.
  int          edge_n, next_free;
  bit          last_l, pend, pend_l, pend_we, pend_mis, win_l;
  logic [31:0] pend_addr, w_addr, w_wdata;
  bit          w_we;
  logic [7:0]  n_ctl;
  logic [31:0] n_rdata, n_maddr, n_mwdata;
  int          lcnt, fcnt;

  initial begin
    drive_idle();

    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                8'b1000_0010, 32'h10, 32'h0, 8'b0100_0000, 32'h0010_0093};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF,
                8'b0001_0001, 32'h20, 32'hDEAD_BEEF, 8'b0000_1000, 32'h0};
    vecs[2] = '{1'b1, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0,
                8'b1000_0000, 32'h0, 32'h0, 8'b0110_0000, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h1234_5678,
                8'b0001_0010, 32'h24, 32'h0, 8'b0000_1000, mem_fn(32'h24)};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'hCAFE_F00D,
                8'b0001_0000, 32'h0, 32'h0, 8'b0000_1100, 32'h0};
    vecs[5] = '{1'b1, 32'h30, 1'b1, 1'b1, 32'h40, 32'h5555_AAAA,
                8'b1000_0010, 32'h30, 32'h0, 8'b0100_0000, mem_fn(32'h30)};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.f_req = vecs[i].f_req; bus.f_addr = vecs[i].f_addr;
      bus.l_req = vecs[i].l_req; bus.l_we = vecs[i].l_we;
      bus.l_addr = vecs[i].l_addr; bus.l_wdata = vecs[i].l_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt_ctl", i), 64'(ctl()), 64'(vecs[i].e_g));
      if (vecs[i].e_g[1:0] != 2'b00)
        chk($sformatf("vec%0d_mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].e_maddr));
      if (vecs[i].e_g[0])
        chk($sformatf("vec%0d_mem_wdata", i), 64'(bus.mem_wdata), 64'(vecs[i].e_mwdata));
      drive_idle();
      @(negedge clk);
      chk($sformatf("vec%0d_resp_ctl", i), 64'(ctl()), 64'(vecs[i].e_r));
      chk($sformatf("vec%0d_rdata", i),
          64'(vecs[i].e_r[6] ? bus.f_rdata : bus.l_rdata), 64'(vecs[i].e_rdata));
      @(negedge clk);
      chk($sformatf("vec%0d_after_ctl", i), 64'(ctl()), 64'h0);
    end

    // Contention: both ports keep requesting; grants every 2 cycles.
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h40;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h44;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("contend_gnt%0d", k), 64'({bus.f_gnt, bus.l_gnt}),
          64'((k % 2 == 0) ? ((RR && ((k / 2) % 2 == 1)) ? 2'b01 : 2'b10) : 2'b00));
    end
    drive_idle();

    // Reset asserted during ACCESS clears outputs immediately and abandons the access.
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h50;
    @(posedge clk);
    #1 chk("rst_mid_access_ctl", 64'(ctl()), 64'(8'b1000_0010));
    #1 resetn = 1'b0;
    bus.f_req = 1'b0;
    #1 chk("rst_mid_async_ctl", 64'(ctl()), 64'h0);
    chk("rst_mid_async_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet%0d", k), 64'(ctl()), 64'h0);
    end

    // Loader request pulsed for one cycle while fetch is in RESP with f_req still high.
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h60;
    lcnt = 0; fcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.l_gnt) lcnt++;
      if (bus.f_rvalid) fcnt++;
      bus.l_req  = (k == 1);
      bus.l_addr = 32'h64;
    end
    chk("withdraw_l_gnts", 64'(lcnt), 64'(RR ? 1 : 0));
    chk("withdraw_f_rvalids", 64'(fcnt), 64'(RR ? 3 : 4));
    drive_idle();

    // Random traffic vs. model: a free arbiter grants at an edge with a pending request,
    // is busy for 2 edges, and answers one edge after the grant.
    do_reset();
    edge_n = 0; next_free = 0; last_l = 1'b1; pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      n_ctl = 8'h0; n_rdata = 32'h0; n_maddr = 32'h0; n_mwdata = 32'h0;
      if (pend) begin
        n_ctl[pend_l ? 3 : 6] = 1'b1;
        n_ctl[pend_l ? 2 : 5] = pend_mis;
        n_rdata = (pend_we || pend_mis) ? 32'h0 : mem_fn(pend_addr);
        pend = 1'b0;
      end
      if (edge_n >= next_free && (bus.f_req || bus.l_req)) begin
        win_l   = (bus.f_req && bus.l_req) ? (RR && !last_l) : bus.l_req;
        w_addr  = win_l ? bus.l_addr : bus.f_addr;
        w_we    = win_l && bus.l_we;
        w_wdata = w_we ? bus.l_wdata : 32'h0;
        n_ctl[win_l ? 4 : 7] = 1'b1;
        if (w_addr[1:0] == 2'b00) n_ctl[w_we ? 0 : 1] = 1'b1;
        n_maddr = w_addr; n_mwdata = w_wdata;
        pend = 1'b1; pend_l = win_l; pend_we = w_we; pend_addr = w_addr;
        pend_mis = (w_addr[1:0] != 2'b00);
        last_l = win_l;
        next_free = edge_n + 2;
      end
      edge_n++;

      @(negedge clk);
      chk($sformatf("rnd%0d_ctl", c), 64'(ctl()), 64'(n_ctl));
      if (n_ctl[1:0] != 2'b00) chk($sformatf("rnd%0d_mem_addr", c), 64'(bus.mem_addr), 64'(n_maddr));
      if (n_ctl[0]) chk($sformatf("rnd%0d_mem_wdata", c), 64'(bus.mem_wdata), 64'(n_mwdata));
      if (n_ctl[6]) chk($sformatf("rnd%0d_f_rdata", c), 64'(bus.f_rdata), 64'(n_rdata));
      if (n_ctl[3]) chk($sformatf("rnd%0d_l_rdata", c), 64'(bus.l_rdata), 64'(n_rdata));

      if (bus.f_gnt || !bus.f_req) begin
        bus.f_req = ($urandom_range(0, 2) == 0);
        bus.f_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.f_req = 1'b0;
      end
      if (bus.l_gnt || !bus.l_req) begin
        bus.l_req = ($urandom_range(0, 2) == 0);
        bus.l_addr = rand_addr();
        bus.l_we = 1'($urandom_range(0, 1));
        bus.l_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.l_req = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
